// File: rtl/stereo_mpx_encoder.sv
// FM stereo multiplex (MPX) encoder.
//
// Builds one composite sample per input tick:
//   mpx = AUDIO_GAIN*(L+R)/2 + AUDIO_GAIN*(L-R)/2 * sin38 + PILOT_GAIN*sin19
// The 38 kHz subcarrier index is the 19 kHz pilot index doubled, so both stay phase-locked.
// The pipeline is a fixed 7-state sequence. An in_tick that arrives while a sample is
// in flight is dropped.
//
// Ports:
//   CLK       system clock (100 MHz)
//   RST       synchronous reset, active-high
//   left      signed left PCM sample, valid with in_tick
//   right     signed right PCM sample, valid with in_tick
//   in_tick   one-cycle strobe, left/right valid
//   mpx       signed composite output, registered, held between out_ticks
//   out_tick  one-cycle strobe, mpx updated; asserted 6 cycles after in_tick
//   phase     pilot phase accumulator, advanced once per produced sample
//   sat_flag  sticky saturation flag, cleared only by RST (MPX_SAT_EN builds only)
//
// Build option:
//   MPX_SAT_EN  when defined, the sum is clamped to 16 bits and sat_flag is present.
//               When undefined, the sum wraps to 16 bits and there is no sat_flag port.

module stereo_mpx_encoder #(
    parameter logic [31:0] PHASE_INC  = 32'd163208757,
    parameter int          AUDIO_GAIN = 14746,
    parameter int          PILOT_GAIN = 3277
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic signed [15:0] left,
    input  logic signed [15:0] right,
    input  logic               in_tick,
    output logic signed [15:0] mpx,
    output logic               out_tick,
    output logic [31:0]        phase
`ifdef MPX_SAT_EN
    ,
    output logic               sat_flag
`endif
);

    typedef enum logic [2:0] {
        StIdle, StLatch, StSine, StMul1, StMul2, StSum, StOut
    } state_e;

    state_e state_q, state_d;

    logic signed [15:0] l_q, r_q;
    logic signed [15:0] s_q, d_q;
    logic signed [15:0] sin19_q, sin38_q;
    logic signed [15:0] m_q, dg_q, pl_q;
    logic signed [15:0] st_q;
    logic signed [17:0] acc_q;

    logic [16:0]        sum_lr, dif_lr;
    logic [7:0]         p19, p38;
    logic signed [15:0] sin19_d, sin38_d;
    logic signed [31:0] prod_m, prod_dg, prod_pl, prod_st;
    logic signed [17:0] acc_d;

    // Quarter-wave ROM: round(32767*sin(2*pi*k/256)), k = 0..64.
    function automatic logic signed [15:0] quarter_sine(input logic [6:0] k);
        logic signed [15:0] q;
        q = 16'sd0;
        case (k)
            7'd0:  q = 16'sd0;     7'd1:  q = 16'sd804;   7'd2:  q = 16'sd1608;
            7'd3:  q = 16'sd2410;  7'd4:  q = 16'sd3212;  7'd5:  q = 16'sd4011;
            7'd6:  q = 16'sd4808;  7'd7:  q = 16'sd5602;  7'd8:  q = 16'sd6393;
            7'd9:  q = 16'sd7179;  7'd10: q = 16'sd7962;  7'd11: q = 16'sd8739;
            7'd12: q = 16'sd9512;  7'd13: q = 16'sd10278; 7'd14: q = 16'sd11039;
            7'd15: q = 16'sd11793; 7'd16: q = 16'sd12539; 7'd17: q = 16'sd13279;
            7'd18: q = 16'sd14010; 7'd19: q = 16'sd14732; 7'd20: q = 16'sd15446;
            7'd21: q = 16'sd16151; 7'd22: q = 16'sd16846; 7'd23: q = 16'sd17530;
            7'd24: q = 16'sd18204; 7'd25: q = 16'sd18868; 7'd26: q = 16'sd19519;
            7'd27: q = 16'sd20159; 7'd28: q = 16'sd20787; 7'd29: q = 16'sd21403;
            7'd30: q = 16'sd22005; 7'd31: q = 16'sd22594; 7'd32: q = 16'sd23170;
            7'd33: q = 16'sd23731; 7'd34: q = 16'sd24279; 7'd35: q = 16'sd24811;
            7'd36: q = 16'sd25329; 7'd37: q = 16'sd25832; 7'd38: q = 16'sd26319;
            7'd39: q = 16'sd26790; 7'd40: q = 16'sd27245; 7'd41: q = 16'sd27683;
            7'd42: q = 16'sd28105; 7'd43: q = 16'sd28510; 7'd44: q = 16'sd28898;
            7'd45: q = 16'sd29268; 7'd46: q = 16'sd29621; 7'd47: q = 16'sd29956;
            7'd48: q = 16'sd30273; 7'd49: q = 16'sd30571; 7'd50: q = 16'sd30852;
            7'd51: q = 16'sd31113; 7'd52: q = 16'sd31356; 7'd53: q = 16'sd31580;
            7'd54: q = 16'sd31785; 7'd55: q = 16'sd31971; 7'd56: q = 16'sd32137;
            7'd57: q = 16'sd32285; 7'd58: q = 16'sd32412; 7'd59: q = 16'sd32521;
            7'd60: q = 16'sd32609; 7'd61: q = 16'sd32678; 7'd62: q = 16'sd32728;
            7'd63: q = 16'sd32757; 7'd64: q = 16'sd32767;
            default: q = 16'sd0;
        endcase
        return q;
    endfunction

    // Full-wave sine from quarter-wave symmetry. Bit 6 selects the mirrored quadrants,
    // where the ROM index is (64 - idx[5:0]) for 64..127 and likewise for 192..255; both
    // reduce to -idx[6:0] mod 128. Bit 7 selects the negative half.
    function automatic logic signed [15:0] sine_lookup(input logic [7:0] idx);
        logic [6:0]         k;
        logic signed [15:0] mag;
        k   = idx[6] ? (7'd0 - idx[6:0]) : idx[6:0];
        mag = quarter_sine(k);
        return idx[7] ? -mag : mag;
    endfunction

    always_comb begin
        sum_lr  = {l_q[15], l_q} + {r_q[15], r_q};
        dif_lr  = {l_q[15], l_q} - {r_q[15], r_q};
        p19     = phase[31:24];
        p38     = {p19[6:0], 1'b0};
        sin19_d = sine_lookup(p19);
        sin38_d = sine_lookup(p38);
        prod_m  = 32'(s_q) * AUDIO_GAIN;
        prod_dg = 32'(d_q) * AUDIO_GAIN;
        prod_pl = 32'(sin19_q) * PILOT_GAIN;
        prod_st = 32'(dg_q) * 32'(sin38_q);
        acc_d   = 18'(m_q) + 18'(st_q) + 18'(pl_q);
    end

    // Bits dropped by the >>>1 and >>>15 scalings.
    logic unused_bits;
    assign unused_bits = ^{sum_lr[0], dif_lr[0], prod_m[31], prod_m[14:0],
                           prod_dg[31], prod_dg[14:0], prod_pl[31], prod_pl[14:0],
                           prod_st[31], prod_st[14:0], acc_q[17:16]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_tick) state_d = StLatch;
            StLatch: state_d = StSine;
            StSine:  state_d = StMul1;
            StMul1:  state_d = StMul2;
            StMul2:  state_d = StSum;
            StSum:   state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            l_q      <= '0;
            r_q      <= '0;
            s_q      <= '0;
            d_q      <= '0;
            sin19_q  <= '0;
            sin38_q  <= '0;
            m_q      <= '0;
            dg_q     <= '0;
            pl_q     <= '0;
            st_q     <= '0;
            acc_q    <= '0;
            mpx      <= '0;
            out_tick <= 1'b0;
            phase    <= '0;
`ifdef MPX_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            out_tick <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_tick) begin
                        l_q <= left;
                        r_q <= right;
                    end
                end
                StLatch: begin
                    s_q <= sum_lr[16:1];
                    d_q <= dif_lr[16:1];
                end
                StSine: begin
                    sin19_q <= sin19_d;
                    sin38_q <= sin38_d;
                end
                StMul1: begin
                    m_q  <= prod_m[30:15];
                    dg_q <= prod_dg[30:15];
                    pl_q <= prod_pl[30:15];
                end
                StMul2: st_q  <= prod_st[30:15];
                StSum:  acc_q <= acc_d;
                StOut: begin
                    out_tick <= 1'b1;
                    // Sample was built from the pre-increment phase.
                    phase    <= phase + PHASE_INC;
`ifdef MPX_SAT_EN
                    if (acc_q > 18'sd32767) begin
                        mpx      <= 16'sh7fff;
                        sat_flag <= 1'b1;
                    end else if (acc_q < -18'sd32768) begin
                        mpx      <= 16'sh8000;
                        sat_flag <= 1'b1;
                    end else begin
                        mpx <= acc_q[15:0];
                    end
`else
                    mpx <= acc_q[15:0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stereo_mpx_encoder.sv
// Self-checking bench for stereo_mpx_encoder. Three instances share one stimulus bus:
// dut_a with default parameters, dut_b with a 2^29 phase step, and (MPX_SAT_EN builds)
// dut_s with full-scale gains. Expected samples are queued at send time and popped when
// the instance under test raises out_tick.

module tb_stereo_mpx_encoder;

    localparam logic [31:0] INC_A = 32'd163208757;
    localparam logic [31:0] INC_B = 32'h2000_0000;
    localparam int          AG_A  = 14746;
    localparam int          PG_A  = 3277;
    localparam real         PI    = 3.14159265358979323846;
`ifdef MPX_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic signed [15:0] left = '0;
    logic signed [15:0] right = '0;
    logic               in_tick = 1'b0;

    logic signed [15:0] mpx_a, mpx_b;
    logic               out_tick_a, out_tick_b;
    logic [31:0]        phase_a, phase_b;
`ifdef MPX_SAT_EN
    logic signed [15:0] mpx_s;
    logic               out_tick_s;
    logic [31:0]        phase_s;
    logic               sat_flag_a, sat_flag_b, sat_flag_s;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_q[$];
    logic [31:0] ph_a, ph_b;

    always #5 CLK = ~CLK;

    stereo_mpx_encoder dut_a (
        .CLK(CLK), .RST(RST), .left(left), .right(right), .in_tick(in_tick),
        .mpx(mpx_a), .out_tick(out_tick_a), .phase(phase_a)
`ifdef MPX_SAT_EN
        , .sat_flag(sat_flag_a)
`endif
    );

    stereo_mpx_encoder #(.PHASE_INC(INC_B)) dut_b (
        .CLK(CLK), .RST(RST), .left(left), .right(right), .in_tick(in_tick),
        .mpx(mpx_b), .out_tick(out_tick_b), .phase(phase_b)
`ifdef MPX_SAT_EN
        , .sat_flag(sat_flag_b)
`endif
    );

`ifdef MPX_SAT_EN
    stereo_mpx_encoder #(.PHASE_INC(INC_B), .AUDIO_GAIN(32767), .PILOT_GAIN(32767)) dut_s (
        .CLK(CLK), .RST(RST), .left(left), .right(right), .in_tick(in_tick),
        .mpx(mpx_s), .out_tick(out_tick_s), .phase(phase_s), .sat_flag(sat_flag_s)
    );
`endif

    // Reference sine computed directly, rounded half away from zero.
    function automatic int full_sin(input int i);
        real x;
        x = 32767.0 * $sin(2.0 * PI * real'(i) / 256.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int model_mpx(input int l, input int r, input logic [31:0] ph,
                                     input int ag, input int pg, input bit sat);
        int                 s, d, p19, p38;
        longint             m, dg, pl, st, acc;
        logic signed [15:0] w;
        s   = (l + r) >>> 1;
        d   = (l - r) >>> 1;
        p19 = int'(ph[31:24]);
        p38 = (2 * p19) % 256;
        m   = (longint'(s) * ag) >>> 15;
        dg  = (longint'(d) * ag) >>> 15;
        pl  = (longint'(full_sin(p19)) * pg) >>> 15;
        st  = (dg * full_sin(p38)) >>> 15;
        acc = m + st + pl;
        if (sat) begin
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
        end
        w = acc[15:0];
        return int'(w);
    endfunction

    function automatic bit tick_of(input int sel);
        case (sel)
            0: return out_tick_a;
            1: return out_tick_b;
`ifdef MPX_SAT_EN
            2: return out_tick_s;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic int mpx_of(input int sel);
        case (sel)
            0: return int'(mpx_a);
            1: return int'(mpx_b);
`ifdef MPX_SAT_EN
            2: return int'(mpx_s);
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] phase_of(input int sel);
        case (sel)
            0: return phase_a;
            1: return phase_b;
`ifdef MPX_SAT_EN
            2: return phase_s;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // All bench actions happen on the falling edge.
    task automatic do_reset(input int n);
        RST = 1'b1;
        in_tick = 1'b0;
        repeat (n) @(negedge CLK);
        RST = 1'b0;
        ph_a = '0;
        ph_b = '0;
        exp_q.delete();
    endtask

    task automatic send_tick(input int l, input int r);
        left = 16'(l);
        right = 16'(r);
        in_tick = 1'b1;
        @(negedge CLK);
        in_tick = 1'b0;
    endtask

    // lat counts rising edges after the one that sampled in_tick; -1 on timeout.
    task automatic wait_out(input int sel, output int got, output logic [31:0] gph,
                            output int lat);
        lat = -1;
        got = 0;
        gph = '0;
        for (int c = 0; c <= 20; c++) begin
            if (tick_of(sel)) begin
                lat = c;
                got = mpx_of(sel);
                gph = phase_of(sel);
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        int got, lat, e;
        logic [31:0] gph;
        do_reset(3);
        n_checks++;
        if (mpx_a !== 16'sd0) begin
            n_errors++; $display("FAIL reset_mpx: got %0d want 0", mpx_a);
        end
        n_checks++;
        if (phase_a !== 32'd0) begin
            n_errors++; $display("FAIL reset_phase: got %0d want 0", phase_a);
        end
        n_checks++;
        if (out_tick_a !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_tick: got %b want 0", out_tick_a);
        end
        exp_q.push_back(0);
        send_tick(0, 0);
        wait_out(0, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 6) begin
            n_errors++; $display("FAIL first_latency: got %0d want 6", lat);
        end
        n_checks++;
        if (got !== e) begin
            n_errors++; $display("FAIL first_mpx: got %0d want %0d", got, e);
        end
        n_checks++;
        if (gph !== INC_A) begin
            n_errors++; $display("FAIL first_phase: got %0d want %0d", gph, INC_A);
        end
        @(negedge CLK);
        n_checks++;
        if (out_tick_a !== 1'b0) begin
            n_errors++; $display("FAIL out_tick_width: got %b want 0", out_tick_a);
        end
    endtask

    task automatic test_mono();
        int got, lat, e;
        logic [31:0] gph;
        do_reset(2);
        exp_q.push_back(7373);
        send_tick(16384, 16384);
        wait_out(0, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_errors++; $display("FAIL mono_mpx: got %0d want %0d", got, e);
        end
        // mpx must hold until the next out_tick.
        repeat (3) @(negedge CLK);
        n_checks++;
        if (int'(mpx_a) !== e) begin
            n_errors++; $display("FAIL mono_hold: got %0d want %0d", mpx_a, e);
        end
    endtask

    task automatic test_stereo();
        int got, lat, e;
        logic [31:0] gph;
        do_reset(2);
        exp_q.push_back(0);
        exp_q.push_back(9689);
        send_tick(16384, -16384);
        wait_out(1, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_errors++; $display("FAIL stereo_tick1: got %0d want %0d", got, e);
        end
        n_checks++;
        if (gph !== INC_B) begin
            n_errors++; $display("FAIL stereo_phase1: got %0d want %0d", gph, INC_B);
        end
        send_tick(16384, -16384);
        wait_out(1, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_errors++; $display("FAIL stereo_tick2: got %0d want %0d", got, e);
        end
    endtask

    task automatic test_pilot();
        int got, lat, e;
        logic [31:0] gph;
        int pilot_exp[8] = '{0, 2317, 3276, 2317, 0, -2318, -3277, -2318};
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pilot_exp[i]);
            send_tick(0, 0);
            wait_out(1, got, gph, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++; $display("FAIL pilot_%0d: got %0d want %0d", i, got, e);
            end
        end
        n_checks++;
        if (phase_b !== 32'd0) begin
            n_errors++; $display("FAIL pilot_phase_wrap: got %0d want 0", phase_b);
        end
    endtask

    task automatic test_drop();
        int n_ticks, e;
        do_reset(2);
        n_ticks = 0;
        exp_q.push_back(model_mpx(1000, 1000, 32'd0, AG_A, PG_A, SAT_EN));
        send_tick(1000, 1000);
        @(negedge CLK);
        left = -16'sd1000;
        right = -16'sd1000;
        in_tick = 1'b1;
        @(negedge CLK);
        in_tick = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_tick_a) begin
                n_ticks++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (int'(mpx_a) !== e) begin
                        n_errors++; $display("FAIL drop_mpx: got %0d want %0d", mpx_a, e);
                    end
                end
            end
            @(negedge CLK);
        end
        n_checks++;
        if (n_ticks !== 1) begin
            n_errors++; $display("FAIL drop_tick_count: got %0d want 1", n_ticks);
        end
        n_checks++;
        if (phase_a !== INC_A) begin
            n_errors++; $display("FAIL drop_phase: got %0d want %0d", phase_a, INC_A);
        end
    endtask

    task automatic test_abort();
        int n_ticks, got, lat, e;
        logic [31:0] gph;
        do_reset(2);
        n_ticks = 0;
        send_tick(2000, -500);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (out_tick_a) n_ticks++;
            @(negedge CLK);
        end
        n_checks++;
        if (n_ticks !== 0) begin
            n_errors++; $display("FAIL abort_tick_count: got %0d want 0", n_ticks);
        end
        n_checks++;
        if (phase_a !== 32'd0) begin
            n_errors++; $display("FAIL abort_phase: got %0d want 0", phase_a);
        end
        exp_q.push_back(model_mpx(2000, -500, 32'd0, AG_A, PG_A, SAT_EN));
        send_tick(2000, -500);
        wait_out(0, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 6 || got !== e) begin
            n_errors++;
            $display("FAIL abort_recover: got mpx %0d lat %0d want mpx %0d lat 6", got, lat, e);
        end
    endtask

    task automatic test_back_to_back();
        int got, lat, e, l, r;
        logic [31:0] gph;
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                l = 32767; r = -32768;
            end else if (i == 1) begin
                l = -32768; r = -32768;
            end else begin
                l = int'($urandom_range(65535)) - 32768;
                r = int'($urandom_range(65535)) - 32768;
            end
            exp_q.push_back(model_mpx(l, r, ph_a, AG_A, PG_A, SAT_EN));
            send_tick(l, r);
            wait_out(0, got, gph, lat);
            e = exp_q.pop_front();
            ph_a = ph_a + INC_A;
            n_checks++;
            if (lat !== 6 || got !== e) begin
                n_errors++;
                $display("FAIL b2b_%0d (L=%0d R=%0d): got mpx %0d lat %0d want mpx %0d lat 6",
                         i, l, r, got, lat, e);
            end
            n_checks++;
            if (gph !== ph_a) begin
                n_errors++; $display("FAIL b2b_phase_%0d: got %0d want %0d", i, gph, ph_a);
            end
        end
    endtask

`ifdef MPX_SAT_EN
    task automatic test_sat();
        int got, lat, e;
        logic [31:0] gph;
        do_reset(2);
        exp_q.push_back(32766);
        exp_q.push_back(32767);
        exp_q.push_back(32766);
        send_tick(32767, 32767);
        wait_out(2, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || sat_flag_s !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_near_full: got mpx %0d sat %b want mpx %0d sat 0",
                     got, sat_flag_s, e);
        end
        send_tick(32767, 32767);
        wait_out(2, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || sat_flag_s !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_clamp: got mpx %0d sat %b want mpx %0d sat 1", got, sat_flag_s, e);
        end
        send_tick(0, 0);
        wait_out(2, got, gph, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || sat_flag_s !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_sticky: got mpx %0d sat %b want mpx %0d sat 1", got, sat_flag_s, e);
        end
        do_reset(2);
        n_checks++;
        if (sat_flag_s !== 1'b0) begin
            n_errors++; $display("FAIL sat_reset: got %b want 0", sat_flag_s);
        end
    endtask
`endif

    initial begin
        @(negedge CLK);
        test_reset();
        test_mono();
        test_stereo();
        test_pilot();
        test_drop();
        test_abort();
        test_back_to_back();
`ifdef MPX_SAT_EN
        test_sat();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
